// File: rtl/slot_pkg.sv
// Shared definitions for the push-button event decoder: event FSM encoding
// and default timing constants for a 50 MHz system clock.
package slot_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } key_state_t;

  localparam int DEF_N_KEYS          = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
  localparam int DEF_LONG_CYCLES     = 50000000;  // 1 s
  localparam int DEF_REPEAT_CYCLES   = 10000000;  // 200 ms

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer on the raw active-low key,
// then a stable-sample counter that accepts a level change after DEBOUNCE_CYCLES.
module key_debounce
  import slot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pressed;

  assign w_pressed = ~r_sync2;
  assign key_level = r_level;

  // Synchronizer resets to the released (high) level so a key held through
  // reset is debounced from scratch once reset lifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      if (w_pressed == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= w_pressed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Debounced push-button decoder: per-key press / release / long-press /
// auto-repeat strobes driven by an independent event FSM per channel.
module key_event_decoder
  import slot_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_KEYS-1:0]     key_n,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     press_pulse,
  output logic [N_KEYS-1:0]     release_pulse,
  output logic [N_KEYS-1:0]     long_pulse,
  output logic [N_KEYS-1:0]     repeat_pulse,
  output logic [2*N_KEYS-1:0]   dbg_state
);

  localparam int LONG_W = $clog2(LONG_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_event_decoder: need DEBOUNCE_CYCLES>=2, LONG_CYCLES>DEBOUNCE_CYCLES, REPEAT_CYCLES>=2");
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_t        r_state;
    key_state_t        w_next;
    logic [LONG_W-1:0] r_hold;
    logic [LONG_W-1:0] w_hold_nxt;
    logic [REP_W-1:0]  r_rep;
    logic [REP_W-1:0]  w_rep_nxt;
    logic              w_level;
    logic              w_hold_done;
    logic              w_rep_done;
    logic              w_press_evt;
    logic              w_rel_evt;
    logic              w_long_evt;
    logic              w_rep_evt;
    logic              r_press;
    logic              r_rel;
    logic              r_long;
    logic              r_rep_p;

    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .key_n     (key_n[k]),
      .key_level (key_level[k])
    );

    assign w_level     = key_level[k];
    assign w_hold_done = (r_hold == LONG_W'(LONG_CYCLES - 1));
    assign w_rep_done  = (r_rep == REP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= ST_RELEASED;
        r_hold  <= '0;
        r_rep   <= '0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
        r_long  <= 1'b0;
        r_rep_p <= 1'b0;
      end else begin
        r_state <= w_next;
        r_hold  <= w_hold_nxt;
        r_rep   <= w_rep_nxt;
        r_press <= w_press_evt;
        r_rel   <= w_rel_evt;
        r_long  <= w_long_evt;
        r_rep_p <= w_rep_evt;
      end
    end

    // Release is checked first so a falling level beats any terminal count.
    always_comb begin
      w_next     = r_state;
      w_hold_nxt = '0;
      w_rep_nxt  = '0;
      case (r_state)
        ST_RELEASED: begin
          if (w_level) w_next = ST_PRESSED;
        end
        ST_PRESSED: begin
          if (!w_level)         w_next = ST_RELEASED;
          else if (w_hold_done) w_next = ST_LONG;
          else                  w_hold_nxt = r_hold + 1'b1;
        end
        ST_LONG: begin
          if (!w_level)        w_next = ST_RELEASED;
          else if (!w_rep_done) w_rep_nxt = r_rep + 1'b1;
        end
        default: w_next = ST_RELEASED;
      endcase
    end

    always_comb begin
      w_press_evt = (r_state == ST_RELEASED) && w_level;
      w_rel_evt   = ((r_state == ST_PRESSED) || (r_state == ST_LONG)) && !w_level;
      w_long_evt  = (r_state == ST_PRESSED) && w_level && w_hold_done;
      w_rep_evt   = (r_state == ST_LONG) && w_level && w_rep_done;
    end

    assign press_pulse[k]       = r_press;
    assign release_pulse[k]     = r_rel;
    assign long_pulse[k]        = r_long;
    assign repeat_pulse[k]      = r_rep_p;
    assign dbg_state[2*k +: 2]  = r_state;
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed timing checks plus randomized key
// traffic compared cycle by cycle against a stable-window reference model.
module tb_key_event_decoder;
  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;
  localparam int W = 5 * N;

  logic           clk;
  logic           rst;
  logic [N-1:0]   key_n;
  logic [N-1:0]   key_level;
  logic [N-1:0]   press_pulse;
  logic [N-1:0]   release_pulse;
  logic [N-1:0]   long_pulse;
  logic [N-1:0]   repeat_pulse;
  logic [2*N-1:0] dbg_state;

  int tot;
  int bad;

  key_event_decoder #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_n         (key_n),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the raw pressed value seen
  // two edges earlier has disagreed with it for D consecutive samples;
  // events are derived from level changes and the age of the current press.
  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_hist [0:D+1];
  logic [N-1:0] m_lvl1;
  logic [N-1:0] m_lvl2;
  int           m_cyc;
  int           m_press_t [N];

  always @(posedge clk) begin : model
    logic [N-1:0] lvl_new, prs, rel, lng, rep;
    bit flip;
    int age;
    if (!rst) begin
      for (int j = 0; j <= D + 1; j++) m_hist[j] = '0;
      m_lvl1 = '0;
      m_lvl2 = '0;
      m_cyc  = 0;
      exp_q.push_back('0);
    end else begin
      m_cyc++;
      for (int j = D + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = ~key_n;
      prs = '0; rel = '0; lng = '0; rep = '0; lvl_new = m_lvl1;
      for (int k = 0; k < N; k++) begin
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (m_hist[j][k] == m_lvl1[k]) flip = 1'b0;
        if (flip) lvl_new[k] = ~m_lvl1[k];
        if (m_lvl1[k] && !m_lvl2[k]) begin
          prs[k] = 1'b1;
          m_press_t[k] = m_cyc;
        end else if (!m_lvl1[k] && m_lvl2[k]) begin
          rel[k] = 1'b1;
        end else if (m_lvl1[k]) begin
          age = m_cyc - m_press_t[k];
          if (age == L) lng[k] = 1'b1;
          else if (age > L && (age - L) % R == 0) rep[k] = 1'b1;
        end
      end
      m_lvl2 = m_lvl1;
      m_lvl1 = lvl_new;
      exp_q.push_back({lvl_new, prs, rel, lng, rep});
    end
  end

  // driver tasks
  task automatic next_cycle(output logic [W-1:0] e, output logic [W-1:0] g);
    @(negedge clk);
    if (exp_q.size() == 0) e = 'x;
    else begin
      e = exp_q[$];
      exp_q.delete();
    end
    g = {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
  endtask

  task automatic drive_reset(input int cycles, input logic [N-1:0] keys);
    logic [W-1:0] e, g;
    rst   = 1'b0;
    key_n = keys;
    repeat (cycles) next_cycle(e, g);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] e, g;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_n = N'($urandom_range(0, (1 << N) - 1));
      next_cycle(e, g);
      tot++;
      if (g !== e || dbg_state !== '0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h state=%h exp=%h state=0", i, g, dbg_state, e);
      end
    end
  endtask

  task automatic test_single_press();
    logic [W-1:0] e, g;
    drive_reset(2, '1);
    key_n = 2'b01;
    for (int i = 1; i <= 14; i++) begin
      next_cycle(e, g);
      tot++;
      if (g !== e || key_level[1] !== (i >= 6) || press_pulse[1] !== (i == 7)) begin
        bad++;
        $display("FAIL single_press edge=%0d got=%h exp=%h lvl1=%b press1=%b", i, g, e,
                 key_level[1], press_pulse[1]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] e, g;
    logic [6:0] pat0;
    int run1;
    bit cur1;
    pat0 = 7'b1110111;
    drive_reset(2, '1);
    run1 = $urandom_range(1, 3);
    cur1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      key_n[0] = (i < 7) ? ~pat0[6 - i] : 1'b1;
      key_n[1] = (i < 15) ? ~cur1 : 1'b1;
      if (--run1 == 0) begin
        cur1 = ~cur1;
        run1 = $urandom_range(1, 3);
      end
      next_cycle(e, g);
      tot++;
      if (g !== e || g !== '0) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h required=0", i, g, e);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [W-1:0] e, g;
    int j;
    logic exp_rep;
    drive_reset(2, '1);
    key_n = 2'b10;
    for (int i = 1; i <= 57; i++) begin
      next_cycle(e, g);
      j = i - 7;
      exp_rep = (j >= 25) && (j < 48) && ((j - 20) % 5 == 0);
      tot++;
      if (g !== e || press_pulse[0] !== (i == 7) || long_pulse[0] !== (j == 20) ||
          repeat_pulse[0] !== exp_rep || release_pulse[0] !== (j == 48)) begin
        bad++;
        $display("FAIL long_repeat rel=%0d got=%h exp=%h p/l/r/rel=%b%b%b%b", j, g, e,
                 press_pulse[0], long_pulse[0], repeat_pulse[0], release_pulse[0]);
      end
      if (j == 41) key_n[0] = 1'b1;
    end
  endtask

  task automatic test_release_at_long();
    logic [W-1:0] e, g;
    int j;
    drive_reset(2, '1);
    key_n = 2'b10;
    for (int i = 1; i <= 35; i++) begin
      next_cycle(e, g);
      j = i - 7;
      tot++;
      if (g !== e || long_pulse[0] !== 1'b0 || release_pulse[0] !== (j == 20) ||
          press_pulse[0] !== (i == 7)) begin
        bad++;
        $display("FAIL release_at_long rel=%0d got=%h exp=%h long=%b rel=%b", j, g, e,
                 long_pulse[0], release_pulse[0]);
      end
      if (j == 13) key_n[0] = 1'b1;
    end
  endtask

  task automatic test_hold_through_reset();
    logic [W-1:0] e, g;
    drive_reset(3, 2'b10);
    for (int i = 1; i <= 10; i++) begin
      next_cycle(e, g);
      tot++;
      if (g !== e || press_pulse[0] !== (i == 7)) begin
        bad++;
        $display("FAIL hold_through_reset edge=%0d got=%h exp=%h press0=%b", i, g, e, press_pulse[0]);
      end
    end
    key_n = '1;
  endtask

  task automatic test_both_and_reset();
    logic [W-1:0] e, g;
    drive_reset(2, '1);
    key_n = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      next_cycle(e, g);
      tot++;
      if (g !== e || press_pulse !== ((i == 7) ? 2'b11 : 2'b00)) begin
        bad++;
        $display("FAIL both_press edge=%0d got=%h exp=%h press=%b", i, g, e, press_pulse);
      end
    end
    rst = 1'b0;
    #1;
    g = {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
    tot++;
    if (g !== '0 || dbg_state !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h state=%h required=0", g, dbg_state);
    end
    key_n = '1;
    next_cycle(e, g);
    next_cycle(e, g);
    rst = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      next_cycle(e, g);
      tot++;
      if (g !== e || release_pulse !== '0) begin
        bad++;
        $display("FAIL post_reset edge=%0d got=%h exp=%h rel=%b", i, g, e, release_pulse);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, g;
    logic [N-1:0] cur;
    int run_left [N];
    int r;
    logic multi;
    drive_reset(2, '1);
    cur = '0;
    for (int k = 0; k < N; k++) run_left[k] = $urandom_range(1, 6);
    for (int i = 0; i < 900; i++) begin
      for (int k = 0; k < N; k++) begin
        if (run_left[k] == 0) begin
          cur[k] = ~cur[k];
          r = $urandom_range(0, 9);
          run_left[k] = (r < 4) ? $urandom_range(1, 3) :
                        (r < 8) ? $urandom_range(4, 12) : $urandom_range(25, 45);
        end
        run_left[k]--;
      end
      key_n = ~cur;
      next_cycle(e, g);
      multi = 1'b0;
      for (int k = 0; k < N; k++)
        if ($countones({press_pulse[k], release_pulse[k], long_pulse[k], repeat_pulse[k]}) > 1)
          multi = 1'b1;
      tot++;
      if (g !== e || multi) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h multi=%b", i, g, e, multi);
      end
    end
  endtask

  // sequence + report
  initial begin
    tot   = 0;
    bad   = 0;
    rst   = 1'b0;
    key_n = '1;
    test_reset();
    test_single_press();
    test_glitch();
    test_long_repeat();
    test_release_at_long();
    test_hold_through_reset();
    test_both_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
